// File: rtl/tcdm_bank_scrub_ctrl.sv
// ----------------------------------------------------------------------------
// tcdm_bank_scrub_ctrl
//
// Per-bank front-end sitting directly upstream of one ECC-protected TCDM SRAM
// bank. It owns the bank port and multiplexes three sources onto it, one per
// cycle, with priority INIT > master > scrub:
//   * an init engine that zero-fills the whole bank after reset or init_i,
//   * interconnect (master) traffic, granted in the same cycle,
//   * a background scrubber that reads idle words and writes back the
//     ECC-corrected data when the bank reports a single-bit error.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   init_i                  pulse: restart zero-fill of the whole bank
//   init_done_o             1 = bank initialised, master traffic accepted
//   scrub_en_i              1 = background scrubbing enabled
//   mst_req_i/mst_gnt_o     master request / same-cycle grant
//   mst_wen_i               0 = write, 1 = read
//   mst_add_i, mst_wdata_i, mst_be_i   master address, write data, byte enables
//   mst_rdata_o/mst_rvalid_o           read data, valid one cycle after a read
//   bank_req_o, bank_wen_o, bank_add_o, bank_wdata_o, bank_be_o  bank port
//   bank_rdata_i            corrected read data, one cycle after a read
//   bank_single_err_i       corrected single-bit error on bank_rdata_i
//   bank_multi_err_i        uncorrectable error on bank_rdata_i
//   scrub_corr_cnt_o        saturating count of scrub single-bit errors
//   scrub_uncorr_cnt_o      saturating count of scrub multi-bit errors
// ----------------------------------------------------------------------------
module tcdm_bank_scrub_ctrl #(
    parameter int BANK_SIZE      = 256,
    parameter int SCRUB_INTERVAL = 64,
    parameter int CNT_W          = 16,
    localparam int AW            = $clog2(BANK_SIZE)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             init_i,
    output logic             init_done_o,
    input  logic             scrub_en_i,
    input  logic             mst_req_i,
    output logic             mst_gnt_o,
    input  logic             mst_wen_i,
    input  logic [AW-1:0]    mst_add_i,
    input  logic [31:0]      mst_wdata_i,
    input  logic [3:0]       mst_be_i,
    output logic [31:0]      mst_rdata_o,
    output logic             mst_rvalid_o,
    output logic             bank_req_o,
    output logic             bank_wen_o,
    output logic [AW-1:0]    bank_add_o,
    output logic [31:0]      bank_wdata_o,
    output logic [3:0]       bank_be_o,
    input  logic [31:0]      bank_rdata_i,
    input  logic             bank_single_err_i,
    input  logic             bank_multi_err_i,
    output logic [CNT_W-1:0] scrub_corr_cnt_o,
    output logic [CNT_W-1:0] scrub_uncorr_cnt_o
);

    localparam int TW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

    localparam logic [TW-1:0]    TMR_LAST  = TW'(SCRUB_INTERVAL - 1);
    localparam logic [AW-1:0]    ADDR_LAST = AW'(BANK_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [1:0] ST_INIT      = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_SCRUB_CHK = 2'd2;
    localparam logic [1:0] ST_SCRUB_WB  = 2'd3;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a == ADDR_LAST) ? '0 : a + AW'(1);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    init_addr_q, init_addr_d;
    logic             init_done_q, init_done_d;
    logic [AW-1:0]    scrub_addr_q, scrub_addr_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [AW-1:0]    wb_addr_q, wb_addr_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             rvalid_q, rvalid_d;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

    // Internal (ungated) bank port and grant
    logic             bank_req, bank_wen;
    logic [AW-1:0]    bank_add;
    logic [31:0]      bank_wdata;
    logic [3:0]       bank_be;
    logic             mst_gnt;
    logic             mst_wr;
    logic             scrub_rd, scrub_wr;

    assign mst_gnt  = (state_q != ST_INIT) && mst_req_i;
    assign mst_wr   = mst_gnt && !mst_wen_i;
    assign rvalid_d = mst_gnt && mst_wen_i;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        init_addr_d  = init_addr_q;
        init_done_d  = init_done_q;
        scrub_addr_d = scrub_addr_q;
        timer_d      = timer_q;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        scrub_rd     = 1'b0;
        scrub_wr     = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (init_addr_q == ADDR_LAST) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    init_addr_d = init_addr_q + AW'(1);
                end
            end

            ST_IDLE: begin
                // Timer only advances while enabled; at its last value it
                // waits for a free bank port instead of wrapping.
                if (scrub_en_i) begin
                    if (timer_q == TMR_LAST) begin
                        if (!mst_req_i) begin
                            scrub_rd = 1'b1;
                            timer_d  = '0;
                            state_d  = ST_SCRUB_CHK;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end

            ST_SCRUB_CHK: begin
                scrub_addr_d = addr_inc(scrub_addr_q);
                state_d      = ST_IDLE;
                if (bank_multi_err_i) begin
                    uncorr_cnt_d = sat_inc(uncorr_cnt_q);
                end else if (bank_single_err_i) begin
                    corr_cnt_d = sat_inc(corr_cnt_q);
                    wb_addr_d  = scrub_addr_q;
                    wb_data_d  = bank_rdata_i;
                    // A master write landing on the same word in this very
                    // cycle already makes the corrected copy stale.
                    if (!(mst_wr && (mst_add_i == scrub_addr_q))) begin
                        state_d = ST_SCRUB_WB;
                    end
                end
            end

            ST_SCRUB_WB: begin
                if (!mst_req_i) begin
                    scrub_wr = 1'b1;
                    state_d  = ST_IDLE;
                end else if (mst_wr && (mst_add_i == wb_addr_q)) begin
                    // Master overwrote the word: the latched copy is stale.
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_INIT;
        endcase

        // init_i overrides everything except the error counters.
        if (init_i) begin
            state_d      = ST_INIT;
            init_addr_d  = '0;
            init_done_d  = 1'b0;
            scrub_addr_d = '0;
            timer_d      = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Bank port multiplexer: INIT > master > scrub
    // ------------------------------------------------------------------------
    always_comb begin
        bank_req   = 1'b0;
        bank_wen   = 1'b0;
        bank_add   = '0;
        bank_wdata = '0;
        bank_be    = '0;
        if (state_q == ST_INIT) begin
            bank_req = 1'b1;
            bank_add = init_addr_q;
            bank_be  = 4'hF;
        end else if (mst_req_i) begin
            bank_req   = 1'b1;
            bank_wen   = mst_wen_i;
            bank_add   = mst_add_i;
            bank_wdata = mst_wdata_i;
            bank_be    = mst_be_i;
        end else if (scrub_rd && !init_i) begin
            bank_req = 1'b1;
            bank_wen = 1'b1;
            bank_add = scrub_addr_q;
            bank_be  = 4'hF;
        end else if (scrub_wr && !init_i) begin
            bank_req   = 1'b1;
            bank_add   = wb_addr_q;
            bank_wdata = wb_data_q;
            bank_be    = 4'hF;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_INIT;
            init_addr_q  <= '0;
            init_done_q  <= 1'b0;
            scrub_addr_q <= '0;
            timer_q      <= '0;
            rvalid_q     <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            init_addr_q  <= init_addr_d;
            init_done_q  <= init_done_d;
            scrub_addr_q <= scrub_addr_d;
            timer_q      <= timer_d;
            rvalid_q     <= rvalid_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    // Writeback payload is only consumed in SCRUB_WB, which is always
    // entered through SCRUB_CHK, so it needs no reset.
    always_ff @(posedge clk_i) begin
        wb_addr_q <= wb_addr_d;
        wb_data_q <= wb_data_d;
    end

    // ------------------------------------------------------------------------
    // Outputs: forced to zero while reset is asserted
    // ------------------------------------------------------------------------
    assign init_done_o        = init_done_q & ~rst_i;
    assign mst_gnt_o          = mst_gnt & ~rst_i;
    assign mst_rvalid_o       = rvalid_q & ~rst_i;
    assign mst_rdata_o        = (rvalid_q && !rst_i) ? bank_rdata_i : 32'h0;
    assign bank_req_o         = bank_req & ~rst_i;
    assign bank_wen_o         = bank_wen & ~rst_i;
    assign bank_add_o         = rst_i ? '0 : bank_add;
    assign bank_wdata_o       = rst_i ? 32'h0 : bank_wdata;
    assign bank_be_o          = rst_i ? 4'h0 : bank_be;
    assign scrub_corr_cnt_o   = rst_i ? '0 : corr_cnt_q;
    assign scrub_uncorr_cnt_o = rst_i ? '0 : uncorr_cnt_q;

endmodule

// File: tb/tb_tcdm_bank_scrub_ctrl.sv
module tb_tcdm_bank_scrub_ctrl;

    localparam int BANK_SIZE = 16;
    localparam int SCRUB_INT = 4;
    localparam int CNT_W     = 2;
    localparam int AW        = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             init_i;
    logic             init_done_o;
    logic             scrub_en_i;
    logic             mst_req_i;
    logic             mst_gnt_o;
    logic             mst_wen_i;
    logic [AW-1:0]    mst_add_i;
    logic [31:0]      mst_wdata_i;
    logic [3:0]       mst_be_i;
    logic [31:0]      mst_rdata_o;
    logic             mst_rvalid_o;
    logic             bank_req_o;
    logic             bank_wen_o;
    logic [AW-1:0]    bank_add_o;
    logic [31:0]      bank_wdata_o;
    logic [3:0]       bank_be_o;
    logic [31:0]      bank_rdata_i;
    logic             bank_single_err_i;
    logic             bank_multi_err_i;
    logic [CNT_W-1:0] scrub_corr_cnt_o;
    logic [CNT_W-1:0] scrub_uncorr_cnt_o;

    tcdm_bank_scrub_ctrl #(
        .BANK_SIZE     (BANK_SIZE),
        .SCRUB_INTERVAL(SCRUB_INT),
        .CNT_W         (CNT_W)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .init_i            (init_i),
        .init_done_o       (init_done_o),
        .scrub_en_i        (scrub_en_i),
        .mst_req_i         (mst_req_i),
        .mst_gnt_o         (mst_gnt_o),
        .mst_wen_i         (mst_wen_i),
        .mst_add_i         (mst_add_i),
        .mst_wdata_i       (mst_wdata_i),
        .mst_be_i          (mst_be_i),
        .mst_rdata_o       (mst_rdata_o),
        .mst_rvalid_o      (mst_rvalid_o),
        .bank_req_o        (bank_req_o),
        .bank_wen_o        (bank_wen_o),
        .bank_add_o        (bank_add_o),
        .bank_wdata_o      (bank_wdata_o),
        .bank_be_o         (bank_be_o),
        .bank_rdata_i      (bank_rdata_i),
        .bank_single_err_i (bank_single_err_i),
        .bank_multi_err_i  (bank_multi_err_i),
        .scrub_corr_cnt_o  (scrub_corr_cnt_o),
        .scrub_uncorr_cnt_o(scrub_uncorr_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // SRAM bank model with error injection on reads
    logic [31:0]   mem [BANK_SIZE];
    logic          inj_single, inj_multi;
    logic [AW-1:0] inj_addr;

    always @(posedge clk_i) begin
        bank_single_err_i <= bank_req_o && bank_wen_o && inj_single && (bank_add_o == inj_addr);
        bank_multi_err_i  <= bank_req_o && bank_wen_o && inj_multi;
        if (bank_req_o) begin
            if (!bank_wen_o) begin
                for (int b = 0; b < 4; b++)
                    if (bank_be_o[b]) mem[bank_add_o][8*b +: 8] <= bank_wdata_o[8*b +: 8];
            end else begin
                bank_rdata_i <= mem[bank_add_o];
            end
        end
    end

    // Scoreboard
    typedef struct {
        logic [AW-1:0] add;
        logic [31:0]   data;
        logic [3:0]    be;
    } wr_t;

    wr_t           exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    logic [31:0]   exp_rdata[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_t e;
        e.add = a; e.data = d; e.be = be;
        exp_wr.push_back(e);
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (bank_req_o && !bank_wen_o) begin
                    if (exp_wr.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_bank_write: addr %0d data 0x%08h, none expected", bank_add_o, bank_wdata_o);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("bank_wr_addr", 32'(bank_add_o), 32'(e.add));
                        chk("bank_wr_data", bank_wdata_o, e.data);
                        chk("bank_wr_be", 32'(bank_be_o), 32'(e.be));
                    end
                end else if (bank_req_o && bank_wen_o) begin
                    if (exp_rd.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_bank_read: addr %0d, none expected", bank_add_o);
                    end else begin
                        chk("bank_rd_addr", 32'(bank_add_o), 32'(exp_rd.pop_front()));
                        chk("bank_rd_be", 32'(bank_be_o), 32'hF);
                    end
                end
                if (mst_rvalid_o) begin
                    if (exp_rdata.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_rvalid: rdata 0x%08h, none expected", mst_rdata_o);
                    end else begin
                        chk("mst_rdata", mst_rdata_o, exp_rdata.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mst(input logic req, input logic wen, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        mst_req_i   = req;
        mst_wen_i   = wen;
        mst_add_i   = a;
        mst_wdata_i = d;
        mst_be_i    = be;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; init_i = 1'b0; scrub_en_i = 1'b0;
        inj_single = 1'b0; inj_multi = 1'b0; inj_addr = '0;
        mst(1'b1, 1'b0, 4'd9, 32'h1111_1111, 4'hF);
        fork monitor(); join_none

        // Reset: everything quiet, even with a master request pending
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_bank_req", 32'(bank_req_o), 0);
        chk("rst_gnt", 32'(mst_gnt_o), 0);
        chk("rst_init_done", 32'(init_done_o), 0);
        chk("rst_rvalid", 32'(mst_rvalid_o), 0);
        chk("rst_corr_cnt", 32'(scrub_corr_cnt_o), 0);
        chk("rst_uncorr_cnt", 32'(scrub_uncorr_cnt_o), 0);

        // T1: zero-fill 0..15, master ignored, init_done at cycle 17
        for (int k = 0; k < BANK_SIZE; k++) push_wr(4'(k), 32'h0, 4'hF);
        rst_i = 1'b0;
        for (int i = 1; i <= BANK_SIZE; i++) begin
            #1;
            chk("init_gnt", 32'(mst_gnt_o), 0);
            chk("init_done_low", 32'(init_done_o), 0);
            step();
        end
        mst(1'b0, 1'b1, 4'd0, 32'h0, 4'h0);
        #1;
        chk("init_done_cycle17", 32'(init_done_o), 1);

        // T2: master write/read
        step();
        mst(1'b1, 1'b0, 4'd5, 32'hDEAD_BEEF, 4'hF);
        push_wr(4'd5, 32'hDEAD_BEEF, 4'hF);
        #1;
        chk("wr_gnt", 32'(mst_gnt_o), 1);
        step();
        mst(1'b1, 1'b1, 4'd5, 32'h0, 4'hF);
        exp_rd.push_back(4'd5);
        exp_rdata.push_back(32'hDEAD_BEEF);
        #1;
        chk("rd_gnt", 32'(mst_gnt_o), 1);
        chk("rvalid_same_cycle", 32'(mst_rvalid_o), 0);
        step();
        mst(1'b1, 1'b0, 4'd0, 32'h1234_5678, 4'hF);
        push_wr(4'd0, 32'h1234_5678, 4'hF);
        #1;
        chk("rvalid_next_cycle", 32'(mst_rvalid_o), 1);
        step();
        mst(1'b1, 1'b0, 4'd2, 32'hAABB_CCDD, 4'b0101);
        push_wr(4'd2, 32'hAABB_CCDD, 4'b0101);
        step();
        mst(1'b1, 1'b1, 4'd2, 32'h0, 4'hF);
        exp_rd.push_back(4'd2);
        exp_rdata.push_back(32'h00BB_00DD);
        step();
        mst(1'b0, 1'b1, 4'd0, 32'h0, 4'h0);
        step();

        // T3: single error at addr 0 -> writeback, next read 4 cycles later
        scrub_en_i = 1'b1; inj_single = 1'b1; inj_addr = 4'd0;
        exp_rd.push_back(4'd0);
        push_wr(4'd0, 32'h1234_5678, 4'hF);
        #1;
        chk("t3_idle_s1", 32'(bank_req_o), 0);
        step(); step(); step();
        #1;
        chk("t3_scrub_rd_req", 32'(bank_req_o), 1);
        chk("t3_scrub_rd_wen", 32'(bank_wen_o), 1);
        step();
        #1;
        chk("t3_chk_idle", 32'(bank_req_o), 0);
        chk("t3_chk_no_rvalid", 32'(mst_rvalid_o), 0);
        step();
        inj_single = 1'b0;
        exp_rd.push_back(4'd1);
        #1;
        chk("t3_wb_req", 32'(bank_req_o), 1);
        chk("t3_wb_wen", 32'(bank_wen_o), 0);
        chk("t3_corr_cnt", 32'(scrub_corr_cnt_o), 1);
        step(); step(); step();
        #1;
        chk("t3_gap_idle", 32'(bank_req_o), 0);
        step();
        #1;
        chk("t3_next_rd", 32'(bank_req_o), 1);
        step();
        scrub_en_i = 1'b0;
        step();

        // T4: single error at addr 3, master write @3 during writeback
        scrub_en_i = 1'b1; inj_single = 1'b1; inj_addr = 4'd3;
        exp_rd.push_back(4'd2);
        exp_rd.push_back(4'd3);
        step(); step(); step();
        #1;
        chk("t4_rd2_req", 32'(bank_req_o), 1);
        step(); step(); step(); step(); step();
        #1;
        chk("t4_rd3_req", 32'(bank_req_o), 1);
        step();
        scrub_en_i = 1'b0; inj_single = 1'b0;
        step();
        mst(1'b1, 1'b0, 4'd3, 32'hCAFE_F00D, 4'hF);
        push_wr(4'd3, 32'hCAFE_F00D, 4'hF);
        #1;
        chk("t4_mst_gnt", 32'(mst_gnt_o), 1);
        chk("t4_bank_wdata", bank_wdata_o, 32'hCAFE_F00D);
        step();
        mst(1'b0, 1'b1, 4'd0, 32'h0, 4'h0);
        #1;
        chk("t4_wb_dropped", 32'(bank_req_o), 0);
        step();
        mst(1'b1, 1'b1, 4'd3, 32'h0, 4'hF);
        exp_rd.push_back(4'd3);
        exp_rdata.push_back(32'hCAFE_F00D);
        step();
        mst(1'b0, 1'b1, 4'd0, 32'h0, 4'h0);
        #1;
        chk("t4_corr_cnt", 32'(scrub_corr_cnt_o), 2);
        step();

        // T5: five multi-bit errors, counter saturates at 3, no writebacks
        scrub_en_i = 1'b1; inj_multi = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) chk("t5_uncorr_cnt", 32'(scrub_uncorr_cnt_o), (k - 1 > 3) ? 3 : 32'(k - 1));
            exp_rd.push_back(4'(3 + k));
            step(); step(); step();
            #1;
            chk("t5_scrub_rd", 32'(bank_req_o), 1);
            step();
            #1;
            chk("t5_no_wb", 32'(bank_req_o), 0);
            step();
        end
        scrub_en_i = 1'b0; inj_multi = 1'b0;
        chk("t5_uncorr_sat", 32'(scrub_uncorr_cnt_o), 3);
        chk("t5_corr_kept", 32'(scrub_corr_cnt_o), 2);

        // T6: init_i while writeback pending -> writeback dropped, full refill
        step();
        scrub_en_i = 1'b1; inj_single = 1'b1; inj_addr = 4'd9;
        exp_rd.push_back(4'd9);
        step(); step(); step();
        #1;
        chk("t6_scrub_rd", 32'(bank_req_o), 1);
        step();
        step();
        scrub_en_i = 1'b0; inj_single = 1'b0;
        mst(1'b1, 1'b1, 4'd7, 32'h0, 4'hF);
        exp_rd.push_back(4'd7);
        exp_rdata.push_back(32'h0);
        #1;
        chk("t6_wb_held", 32'(bank_wen_o), 1);
        step();
        mst(1'b0, 1'b1, 4'd0, 32'h0, 4'h0);
        init_i = 1'b1;
        for (int k = 0; k < BANK_SIZE; k++) push_wr(4'(k), 32'h0, 4'hF);
        #1;
        chk("t6_wb_aborted", 32'(bank_req_o), 0);
        step();
        init_i = 1'b0;
        for (int i = 1; i <= BANK_SIZE; i++) begin
            #1;
            chk("t6_init_done_low", 32'(init_done_o), 0);
            step();
        end
        #1;
        chk("t6_init_done", 32'(init_done_o), 1);
        chk("t6_corr_kept", 32'(scrub_corr_cnt_o), 3);
        chk("t6_uncorr_kept", 32'(scrub_uncorr_cnt_o), 3);
        step();
        mst(1'b1, 1'b1, 4'd5, 32'h0, 4'hF);
        exp_rd.push_back(4'd5);
        exp_rdata.push_back(32'h0);
        step();
        mst(1'b0, 1'b1, 4'd0, 32'h0, 4'h0);
        step(); step();

        chk("wr_queue_drained", 32'(exp_wr.size()), 0);
        chk("rd_queue_drained", 32'(exp_rd.size()), 0);
        chk("rdata_queue_drained", 32'(exp_rdata.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
